// File: rtl/rcc_pkg.sv
// ---------------------------------------------------------------------------
// rcc_pkg
// Shared types and constants for the RCC clock-divider control logic.
//   rcc_state_e      : ratio-update sequencer states.
//   RCC_TIMEOUT_DEF  : default per-wait-state timeout in controller cycles.
//   RCC_CNT_WID      : counter width that holds RCC_TIMEOUT_DEF.
//   rcc_cnt_wid()    : counter width for an arbitrary timeout value.
// ---------------------------------------------------------------------------
package rcc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OFF = 2'd1,
    WAIT_ON  = 2'd2
  } rcc_state_e;

  localparam int unsigned RCC_TIMEOUT_DEF = 1023;
  localparam int unsigned RCC_CNT_WID     = $clog2(RCC_TIMEOUT_DEF + 1);

  // Width of a counter that has to reach 'timeout' without wrapping.
  function automatic int unsigned rcc_cnt_wid(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/BB_signal_sync.sv
// ---------------------------------------------------------------------------
// BB_signal_sync
// Multi-stage flip-flop synchroniser for signals that are asynchronous to clk.
//   clk   in  : destination clock
//   rst_n in  : asynchronous active-low reset, clears every stage
//   din   in  : DW-bit asynchronous input
//   dout  out : DW-bit input delayed by STAGE_NUM clk cycles
// ---------------------------------------------------------------------------
module BB_signal_sync #(
  parameter int unsigned STAGE_NUM = 2,
  parameter int unsigned DW        = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] stage_reg [STAGE_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGE_NUM); i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < int'(STAGE_NUM); i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[STAGE_NUM-1];

endmodule

// File: rtl/rcc_div_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// rcc_div_ratio_ctrl
// Break-before-make sequencer for the ratio input of rcc_clk_div_d. A new
// non-zero ratio is only applied after the divider has been gated (ratio=0)
// and has reported that it stopped; every value driven on 'ratio' is held for
// at least HOLD_CYC cycles so the divider-side synchroniser sees a stable bus.
//   clk      in  : controller (register-bus) clock
//   rst_n    in  : asynchronous active-low reset
//   wr_en    in  : single-cycle ratio write request (ignored while busy)
//   wr_ratio in  : requested ratio, 0 stops the divided clock
//   div_en   in  : divider running status, asynchronous to clk
//   err_clr  in  : clears the sticky error flag
//   ratio    out : registered ratio driven to the divider
//   busy     out : high while a sequence is in progress
//   done     out : one-cycle pulse when a write completes
//   err      out : sticky timeout flag
// ---------------------------------------------------------------------------
module rcc_div_ratio_ctrl
  import rcc_pkg::*;
#(
  parameter int unsigned RATIO_WID = 8,
  parameter int unsigned RST_RATIO = 1,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [RATIO_WID-1:0] wr_ratio,
  input  logic                 div_en,
  input  logic                 err_clr,
  output logic [RATIO_WID-1:0] ratio,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned          CNT_WID     = rcc_cnt_wid(TIMEOUT);
  localparam logic [CNT_WID-1:0]   HOLD_LAST   = CNT_WID'(HOLD_CYC - 1);
  localparam logic [CNT_WID-1:0]   TIMEOUT_CNT = CNT_WID'(TIMEOUT);
  localparam logic [RATIO_WID-1:0] RST_VAL     = RATIO_WID'(RST_RATIO);

  logic                 div_en_s;

  rcc_state_e           state_reg,  state_next;
  logic [CNT_WID-1:0]   cnt_reg,    cnt_next;
  logic [RATIO_WID-1:0] ratio_reg,  ratio_next;
  logic [RATIO_WID-1:0] target_reg, target_next;
  logic                 busy_reg,   busy_next;
  logic                 done_reg,   done_next;
  logic                 err_reg,    err_next;
  logic                 err_set;

  BB_signal_sync #(
    .STAGE_NUM (2),
    .DW        (1)
  ) u_div_en_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (div_en),
    .dout  (div_en_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      ratio_reg  <= RST_VAL;
      target_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ratio_reg  <= ratio_next;
      target_reg <= target_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = (cnt_reg == TIMEOUT_CNT) ? cnt_reg : cnt_reg + CNT_WID'(1);
    ratio_next  = ratio_reg;
    target_next = target_reg;
    done_next   = 1'b0;
    err_set     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (wr_en) begin
          target_next = wr_ratio;
          if (wr_ratio == ratio_reg) begin
            done_next = 1'b1;
          end else if (ratio_reg == '0) begin
            // Divider already gated: no need for the break phase.
            ratio_next = wr_ratio;
            state_next = WAIT_ON;
          end else begin
            ratio_next = '0;
            state_next = WAIT_OFF;
          end
        end
      end
      WAIT_OFF: begin
        // A satisfied exit condition wins over a coincident timeout.
        if (cnt_reg >= HOLD_LAST && !div_en_s) begin
          if (target_reg != '0) begin
            ratio_next = target_reg;
            state_next = WAIT_ON;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else if (cnt_reg == TIMEOUT_CNT) begin
          err_set    = 1'b1;
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      WAIT_ON: begin
        if (cnt_reg >= HOLD_LAST && div_en_s) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          err_set    = 1'b1;
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Every state entry restarts the hold/timeout count.
    if (state_next != state_reg) begin
      cnt_next = '0;
    end

    busy_next = (state_next != IDLE);
    err_next  = err_set | (err_reg & ~err_clr);
  end

  assign ratio = ratio_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_rcc_div_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rcc_div_ratio_ctrl
// Directed bench for rcc_div_ratio_ctrl with default parameters. The divider
// is modelled as div_en following (ratio != 0) three clocks later, sampled on
// the falling edge; stuck_mode forces div_en high. Outputs are sampled 1 ns
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_rcc_div_ratio_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_ratio = 8'd0;
  logic       div_en = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] ratio;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  bit stuck_mode = 1'b0;
  logic [2:0] en_sr = 3'b111;

  rcc_div_ratio_ctrl #(
    .RATIO_WID (8),
    .RST_RATIO (1),
    .HOLD_CYC  (4),
    .TIMEOUT   (1023)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_ratio (wr_ratio),
    .div_en   (div_en),
    .err_clr  (err_clr),
    .ratio    (ratio),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Divider model: div_en reflects (ratio != 0) three falling edges later.
  initial begin
    forever begin
      @(negedge clk);
      en_sr  = {en_sr[1:0], (ratio != 8'd0)};
      div_en = stuck_mode ? 1'b1 : en_sr[2];
    end
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_ratio;
    logic       err_clr;
    logic [7:0] exp_ratio;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] r, input logic b,
                         input logic d, input logic e);
    chk({name, ".ratio"}, 32'(ratio), 32'(r));
    chk({name, ".busy"},  32'(busy),  32'(b));
    chk({name, ".done"},  32'(done),  32'(d));
    chk({name, ".err"},   32'(err),   32'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle write; returns sampled just after the accept edge.
  task automatic do_write(input logic [7:0] t);
    wr_en    = 1'b1;
    wr_ratio = t;
    step();
    wr_en    = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'd1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'd1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};

    // Reset state.
    repeat (2) step();
    chk_all("reset", 8'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset release: values held.
    for (int i = 0; i < 20; i++) begin
      step();
      chk_all("idle_hold", 8'd1, 1'b0, 1'b0, 1'b0);
    end
    $display("txn idle_hold: 20 cycles ratio=%0d busy=%0d", ratio, busy);

    // Table: idle cycles, err_clr without error, same-value writes.
    for (int i = 0; i < 7; i++) begin
      wr_en    = vecs[i].wr_en;
      wr_ratio = vecs[i].wr_ratio;
      err_clr  = vecs[i].err_clr;
      step();
      wr_en   = 1'b0;
      err_clr = 1'b0;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_ratio, vecs[i].exp_busy,
              vecs[i].exp_done, vecs[i].exp_err);
      $display("txn vec%0d: wr_en=%0d wr_ratio=%0d -> ratio=%0d busy=%0d done=%0d err=%0d",
               i, vecs[i].wr_en, vecs[i].wr_ratio, ratio, busy, done, err);
    end

    // Write 5 from 1: ratio 1 -> 0 (5 cycles) -> 5, done 11 cycles after accept.
    do_write(8'd5);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) step();
      chk_all($sformatf("wr5_k%0d", k), (k <= 5) ? 8'd0 : 8'd5,
              (k <= 10), (k == 11), 1'b0);
    end
    $display("txn write 5: ratio=%0d", ratio);

    // Write 0 from 5: gate, wait for div_en_s low, finish in IDLE at 0.
    do_write(8'd0);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      chk_all($sformatf("wr0_k%0d", k), 8'd0, (k <= 5), (k == 6), 1'b0);
    end
    $display("txn write 0: ratio=%0d", ratio);
    repeat (4) step();

    // Write 7 from 0: direct load, done once div_en_s rises.
    do_write(8'd7);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      chk_all($sformatf("wr7_k%0d", k), 8'd7, (k <= 5), (k == 6), 1'b0);
    end
    $display("txn write 7: ratio=%0d", ratio);

    // Write 9 with div_en stuck high: timeout in WAIT_OFF; a write while busy is ignored.
    stuck_mode = 1'b1;
    repeat (3) step();
    do_write(8'd9);
    for (int k = 1; k <= 1027; k++) begin
      if (k > 1) begin
        wr_en    = (k == 10);
        wr_ratio = 8'd3;
        step();
        wr_en    = 1'b0;
      end
      chk_all($sformatf("tmo_k%0d", k), 8'd0, (k <= 1024), (k == 1025), (k >= 1025));
    end
    $display("txn write 9 timeout: ratio=%0d err=%0d", ratio, err);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk_all("err_clr", 8'd0, 1'b0, 1'b0, 1'b0);
    $display("txn err_clr: err=%0d", err);

    // Reset during WAIT_ON: asynchronous return to reset values, no done.
    stuck_mode = 1'b0;
    repeat (8) step();
    do_write(8'd5);
    chk_all("rst_seq_k1", 8'd5, 1'b1, 1'b0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 8'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("rst_held", 8'd1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk_all("rst_after", 8'd1, 1'b0, 1'b0, 1'b0);
    end
    $display("txn reset mid WAIT_ON: ratio=%0d busy=%0d", ratio, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
